// File: rtl/im_loader_if.sv
// Byte-stream and IM write-port bundle between a program source and im_loader.
// Latency: none, wires only.
// Backpressure: byte_valid/byte_ready handshake; the source holds a byte until it is accepted.
interface im_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-2:0] word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              rst_pc_hold;
  logic              busy;
  logic              done;
  logic              err_ovf;
  logic [7:0]        chksum;

  // Source / control side.
  modport master (
    output start, base_addr, word_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, rst_pc_hold, busy, done, err_ovf, chksum
  );

  // Loader side.
  modport slave (
    input  start, base_addr, word_count, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, rst_pc_hold, busy, done, err_ovf, chksum
  );
endinterface

// File: rtl/im_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to IM, holding the PC in reset.
// Latency: one word per 5 cycles streaming (4 accepts + 1 write); done one cycle after the last write.
// Backpressure: byte_ready only in COLLECT; bytes offered in other states stay with the source.
// Optional: IM_LOADER_CHKSUM_EN builds the 8-bit running checksum, otherwise chksum is tied to 0.
module im_loader #(
  parameter int IM_BYTES = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic      clk,
  input  logic      rst_ldr_n,
  im_loader_if.slave bus
);
  localparam int RW = ADDR_W - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_waddr;
  logic [RW-1:0]     r_remaining;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [31:0]       r_wdata;
  logic              r_err_ovf;
  logic              w_accept;
  logic              w_last_byte;
  logic              w_wrap;

  assign w_accept    = (r_state == S_COLLECT) && bus.byte_valid;
  assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
  assign w_wrap      = (r_addr == ADDR_W'(IM_BYTES - 4));

  assign bus.byte_ready  = (r_state == S_COLLECT);
  assign bus.im_we       = (r_state == S_WRITE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.rst_pc_hold = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.im_waddr    = r_waddr;
  assign bus.im_wdata    = r_wdata;
  assign bus.err_ovf     = r_err_ovf;

  // Next-state selection for the IDLE/COLLECT/WRITE/DONE sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = (bus.word_count == '0) ? S_DONE : S_COLLECT;
      S_COLLECT: if (w_last_byte) w_next = S_WRITE;
      S_WRITE:   w_next = (r_remaining == RW'(1)) ? S_DONE : S_COLLECT;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_ldr_n) begin
    if (!rst_ldr_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Address/count bookkeeping, byte assembly and the sticky wrap flag.
  always_ff @(posedge clk or negedge rst_ldr_n) begin
    if (!rst_ldr_n) begin
      r_addr      <= '0;
      r_waddr     <= '0;
      r_remaining <= '0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
      r_wdata     <= '0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_addr      <= bus.base_addr & ~ADDR_W'(3);
        r_remaining <= bus.word_count;
        r_byte_cnt  <= '0;
        r_err_ovf   <= 1'b0;
      end
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // First byte ends up in the MSB after three shifts.
        r_asm      <= {r_asm[15:0], bus.byte_data};
      end
      // Output word/address only change when a complete word is ready.
      if (w_last_byte) begin
        r_wdata <= {r_asm, bus.byte_data};
        r_waddr <= r_addr;
      end
      if (r_state == S_WRITE) begin
        r_addr      <= r_addr + ADDR_W'(4);
        r_remaining <= r_remaining - RW'(1);
        if (w_wrap) r_err_ovf <= 1'b1;
      end
    end
  end

`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0] r_chksum;

  // Wrapping sum of accepted bytes, cleared on each new load.
  always_ff @(posedge clk or negedge rst_ldr_n) begin
    if (!rst_ldr_n) begin
      r_chksum <= 8'h00;
    end else if (r_state == S_IDLE && bus.start) begin
      r_chksum <= 8'h00;
    end else if (w_accept) begin
      r_chksum <= r_chksum + bus.byte_data;
    end
  end

  assign bus.chksum = r_chksum;
`else
  assign bus.chksum = 8'h00;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table of load vectors plus a mid-load reset sequence.
// Expected IM writes are queued when a load is started and matched against observed writes.
// Bounded waits everywhere; an expired bound counts as a failure.
module tb_im_loader;
  logic clk;
  logic rst_ldr_n;
  int   tests;
  int   fails;
  int   cyc;

  im_loader_if #(.ADDR_W(10)) bus ();

  im_loader #(.IM_BYTES(1024), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst_ldr_n (rst_ldr_n),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [9:0]  base;
    logic [8:0]  cnt;
    int          nbytes;
    logic [63:0] bytes;
    bit          gap;
    int          nw;
    logic [9:0]  wa0;
    logic [31:0] wd0;
    logic [9:0]  wa1;
    logic [31:0] wd1;
    logic        ovf;
    logic [7:0]  chk;
    int          lat;
  } vec_t;

  vec_t        vec [0:4];
  logic [41:0] exp_q [$];
  logic [41:0] obs_a [0:63];
  int          obs_n;
  int          done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every IM write and done pulse seen by the fetch side.
  always @(negedge clk) begin
    if (bus.im_we && obs_n < 64) begin
      obs_a[obs_n] = {bus.im_waddr, bus.im_wdata};
      obs_n = obs_n + 1;
    end
    if (bus.done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit gap);
    bit r;
    int n;
    if (gap) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    n = 0;
    do begin
      r = bus.byte_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    if (!r) chk("byte_accept_timeout", 0, 1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] base, input logic [8:0] cnt);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          t0, d0, w0, n;
    logic [41:0] e;
    logic [7:0]  xchk;
    v = vec[i];
`ifdef IM_LOADER_CHKSUM_EN
    xchk = v.chk;
`else
    xchk = 8'h00;
`endif
    do_start(v.base, v.cnt);
    t0 = cyc; d0 = done_cnt; w0 = obs_n;
    chk($sformatf("v%0d busy_after_start", i), bus.busy, 1);
    chk($sformatf("v%0d hold_after_start", i), bus.rst_pc_hold, 1);
    chk($sformatf("v%0d ready_after_start", i), bus.byte_ready, (v.cnt != 0));
    chk($sformatf("v%0d ovf_cleared", i), bus.err_ovf, 0);
    chk($sformatf("v%0d chk_cleared", i), bus.chksum, 0);
    if (v.nw > 0) exp_q.push_back({v.wa0, v.wd0});
    if (v.nw > 1) exp_q.push_back({v.wa1, v.wd1});
    for (int k = 0; k < v.nbytes; k++) begin
      logic [63:0] b;
      b = v.bytes << (8 * k);
      send(b[63:56], v.gap);
    end
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d done_seen", i), bus.done, 1);
    if (v.lat >= 0) chk($sformatf("v%0d done_latency", i), cyc - t0, v.lat);
    chk($sformatf("v%0d hold_during_done", i), bus.rst_pc_hold, 1);
    chk($sformatf("v%0d err_ovf", i), bus.err_ovf, v.ovf);
    chk($sformatf("v%0d chksum", i), bus.chksum, xchk);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_one_cycle", i), bus.done, 0);
    chk($sformatf("v%0d hold_released", i), bus.rst_pc_hold, 0);
    chk($sformatf("v%0d idle_not_busy", i), bus.busy, 0);
    chk($sformatf("v%0d err_ovf_sticky", i), bus.err_ovf, v.ovf);
    chk($sformatf("v%0d chksum_held", i), bus.chksum, xchk);
    chk($sformatf("v%0d done_pulses", i), done_cnt - d0, 1);
    chk($sformatf("v%0d write_count", i), obs_n - w0, v.nw);
    for (int j = 0; j < v.nw; j++) begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d write%0d", i, j), obs_a[w0 + j], e);
    end
    exp_q.delete();
  endtask

  initial begin
    int w0;
    tests = 0; fails = 0; cyc = 0; obs_n = 0; done_cnt = 0;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;

    //        base     cnt  nb bytes                  gap  nw wa0      wd0           wa1      wd1           ovf   chk    lat
    vec[0] = '{10'h000, 9'd2, 8, 64'h8C01000420020005, 1'b0, 2, 10'h000, 32'h8C010004, 10'h004, 32'h20020005, 1'b0, 8'hB8, 10};
    vec[1] = '{10'h100, 9'd1, 4, 64'h1234567800000000, 1'b1, 1, 10'h100, 32'h12345678, 10'h000, 32'h0,        1'b0, 8'h14, -1};
    vec[2] = '{10'h3FE, 9'd2, 8, 64'h1122334455667788, 1'b0, 2, 10'h3FC, 32'h11223344, 10'h000, 32'h55667788, 1'b1, 8'h64, 10};
    vec[3] = '{10'h010, 9'd0, 0, 64'h0,                1'b0, 0, 10'h000, 32'h0,        10'h000, 32'h0,        1'b0, 8'h00, 0};
    vec[4] = '{10'h020, 9'd1, 4, 64'hFF01102000000000, 1'b0, 1, 10'h020, 32'hFF011020, 10'h000, 32'h0,        1'b0, 8'h30, 5};

    rst_ldr_n = 1'b0;
    #3;
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_im_we", bus.im_we, 0);
    chk("rst_im_waddr", bus.im_waddr, 0);
    chk("rst_im_wdata", bus.im_wdata, 0);
    chk("rst_pc_hold", bus.rst_pc_hold, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    chk("rst_chksum", bus.chksum, 0);
    @(posedge clk); #1;
    rst_ldr_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset in the middle of a word: nothing written, everything back to reset values.
    w0 = obs_n;
    do_start(10'h040, 9'd1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    chk("mid_busy_before_reset", bus.busy, 1);
    #2;
    rst_ldr_n = 1'b0;
    #1;
    chk("mid_rst_byte_ready", bus.byte_ready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pc_hold", bus.rst_pc_hold, 0);
    chk("mid_rst_im_we", bus.im_we, 0);
    chk("mid_rst_im_waddr", bus.im_waddr, 0);
    chk("mid_rst_im_wdata", bus.im_wdata, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_err_ovf", bus.err_ovf, 0);
    chk("mid_rst_chksum", bus.chksum, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_ldr_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_write", obs_n - w0, 0);
    run_vec(1);
    run_vec(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/im_loader.md
# im_loader

Program loader that fills the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS words. Each word is written through a single-cycle write port at consecutive word addresses. While a load is in progress it holds the PC in reset, so fetch only starts once the image is complete.

## Interface
Parameters:
- IM_BYTES, 1024, instruction memory size in bytes; must be a power of two.
- ADDR_W, 10, byte-address width; equals log2(IM_BYTES).

Ports:
- clk  in  1  rising-edge clock shared with fetch.
- rst_ldr_n  in  1  asynchronous, active-low reset.
- start  in  1  load request, sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; bits [1:0] ignored (forced word-aligned); latched on start.
- word_count  in  ADDR_W-1  number of words to load; latched on start.
- byte_valid  in  1  stream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte.
- im_we  out  1  IM write strobe, one cycle per word.
- im_waddr  out  ADDR_W  word-aligned IM byte address.
- im_wdata  out  32  assembled word.
- rst_pc_hold  out  1  high while loading; ORed into the PC reset.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of load.
- err_ovf  out  1  sticky; set when the address wraps past IM_BYTES-4.
- chksum  out  8  running byte checksum (see Configuration).

## Operation
The FSM has four states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr & ~3 into addr and word_count into remaining, and clears err_ovf and chksum.
  - If the latched count is 0, go to DONE; otherwise go to COLLECT.
  - start in any other state is ignored.
- COLLECT:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready, and byte_cnt (2 bits) increments.
  - Byte k (k=0..3) lands in im_wdata[31-8k -: 8]; the first byte is the MSB.
  - The 4th accepted byte moves the FSM to WRITE.
- WRITE:
  - byte_ready=0 and im_we=1 for exactly this cycle, with im_waddr=addr.
  - Then addr advances by 4 and remaining decrements.
  - Next state is DONE if remaining was 1, otherwise COLLECT.
- Address wrap: when addr=IM_BYTES-4 the next address is 0 (modulo IM_BYTES), and err_ovf is set. The load still continues.
- DONE: done=1 for one cycle, then the FSM returns to IDLE.
- rst_pc_hold is 1 in COLLECT, WRITE and DONE, and 0 in IDLE.
- byte_valid with no accepted byte (IDLE, WRITE, DONE): the byte is not consumed; the source must hold it.

## Timing
- Reset values: state=IDLE, byte_ready=0, im_we=0, im_waddr=0, im_wdata=0, rst_pc_hold=0, busy=0, done=0, err_ovf=0, chksum=0.
- Reset asserted mid-load:
  - Every output takes its reset value immediately (asynchronous).
  - A partially assembled word is discarded and no write is issued.
- start seen at edge E: busy=1, rst_pc_hold=1 and byte_ready=1 from E.
- 4th byte accepted at edge N: im_we=1 during cycle N..N+1, and IM captures the word at edge N+1.
- Back-to-back streaming gives one word per 5 cycles (4 accept cycles + 1 WRITE cycle).
- Last WRITE at edge M: done=1 during M..M+1, rst_pc_hold falls at M+1, and fetch can start at M+2.
- im_waddr and im_wdata hold their last values outside WRITE.

## Configuration
- IM_LOADER_CHKSUM_EN defined:
  - chksum is the 8-bit wrapping sum of all accepted bytes.
  - It is cleared on start and stays valid after done until the next start.
- IM_LOADER_CHKSUM_EN undefined:
  - The checksum logic is not built and chksum is tied to 8'h00.
  - The port list is the same in both builds.

## Test plan
- Reset, base_addr=0, word_count=2, stream 8C 01 00 04 20 02 00 05 with no gaps:
  - writes 8C010004@0x000 and 20020005@0x004;
  - done pulses once;
  - rst_pc_hold falls the cycle after done.
- byte_valid toggled 1/0 each cycle, word_count=1, bytes 12 34 56 78: a single write of 12345678@base; no byte is dropped or duplicated.
- base_addr=0x3FE (→0x3FC), word_count=2:
  - writes at 0x3FC then 0x000;
  - err_ovf=1 after the second write and stays 1 until the next start.
- word_count=0: done pulses 1 cycle after start; im_we never asserts.
- Assert rst_ldr_n=0 after 2 bytes of the first word:
  - all outputs go to their reset values at once;
  - no write occurs;
  - a new start loads correctly.
- With IM_LOADER_CHKSUM_EN, bytes FF 01 10 20: chksum=0x30 after done; without the macro, chksum=0x00 throughout.
